// File: rtl/fir_pkg.sv
// Constants and elaboration-time helpers shared by the FIR output stage.
package fir_pkg;

  localparam int FIR_IN_W  = 32;
  localparam int FIR_OUT_W = 16;

  // Returns the number of bits needed to index value entries.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

  function automatic longint sat_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic longint sat_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

  localparam longint SAT_MAX = sat_max(FIR_OUT_W);
  localparam longint SAT_MIN = sat_min(FIR_OUT_W);

endpackage

// File: rtl/fir_out_requant_if.sv
// Sample stream in from the filter and requantized stream out to the sink.
interface fir_out_requant_if #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 16
);
  logic                    in_valid;
  logic signed [IN_W-1:0]  y;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] out_data;

  modport master (output in_valid, y, out_ready, input out_valid, out_data);
  modport slave  (input in_valid, y, out_ready, output out_valid, out_data);
endinterface

// File: rtl/fir_out_requant_sync_fifo.sv
// First-word-fall-through FIFO whose head register lags writes by one edge
// but follows pops immediately, so the head never repeats or skips an entry.
module sync_fifo
  import fir_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = FIR_OUT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [WIDTH-1:0]        wr_data,
  input  logic                    rd_ready,
  output logic                    rd_valid,
  output logic [WIDTH-1:0]        rd_data,
  output logic [clog2(DEPTH):0]   level,
  output logic                    drop
);
  localparam int AW = clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r, rd_ptr_r, head_idx_s;
  logic [LW-1:0]    level_r, head_cnt_s, level_nxt_s;
  logic             valid_r;
  logic [WIDTH-1:0] data_r;
  logic             pop_s, full_s, wr_ok_s;

  // Handshake decode; head_cnt_s counts entries left after this edge's pop.
  always_comb begin
    pop_s       = valid_r & rd_ready;
    full_s      = (level_r == LW'(DEPTH));
    wr_ok_s     = wr_en & (~full_s | pop_s);
    drop        = wr_en & full_s & ~pop_s;
    head_cnt_s  = level_r - LW'(pop_s);
    head_idx_s  = rd_ptr_r + AW'(pop_s);
    level_nxt_s = head_cnt_s + LW'(wr_ok_s);
  end

  // Pointers, occupancy and the registered head.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
      valid_r  <= 1'b0;
      data_r   <= '0;
    end else begin
      if (wr_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      end
      rd_ptr_r <= head_idx_s;
      level_r  <= level_nxt_s;
      valid_r  <= (head_cnt_s != '0);
      data_r   <= (head_cnt_s != '0) ? mem_r[head_idx_s] : '0;
    end
  end

  // Storage array.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_r <= '{default: '0};
    end else if (wr_ok_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  assign rd_valid = valid_r;
  assign rd_data  = data_r;
  assign level    = level_r;

endmodule

// File: rtl/fir_out_requant.sv
// FIR output stage: decimate, round half-up, shift, saturate, then buffer
// in a FWFT FIFO with saturation and dropped-sample status.
module fir_out_requant
  import fir_pkg::*;
#(
  parameter int IN_W  = FIR_IN_W,
  parameter int OUT_W = FIR_OUT_W,
  parameter int SHIFT = 15,
  parameter int DECIM = 4,
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  fir_out_requant_if.slave      bus,
  output logic [clog2(DEPTH):0] fifo_level,
  output logic                  sat_sticky,
  input  logic                  clr_flags,
  output logic [CNT_W-1:0]      drop_cnt
);
  localparam int TW = IN_W + 1;
  localparam int PW = (DECIM > 1) ? clog2(DECIM) : 1;
  localparam logic signed [TW-1:0] RND =
    (SHIFT == 0) ? {TW{1'b0}} : TW'(64'sd1 <<< ((SHIFT > 0) ? SHIFT - 1 : 0));
  localparam logic signed [TW-1:0] MAX_T = TW'(sat_max(OUT_W));
  localparam logic signed [TW-1:0] MIN_T = TW'(sat_min(OUT_W));

  logic signed [TW-1:0]    t_s, r_s;
  logic signed [OUT_W-1:0] q_s;
  logic                    sat_s, keep_s, drop_s;
  logic [PW-1:0]           phase_r;
  logic                    stage_valid_r;
  logic signed [OUT_W-1:0] stage_data_r;

  // One extra bit keeps the rounding add from wrapping near the positive limit.
  always_comb begin
    keep_s = bus.in_valid && (phase_r == '0);
    t_s    = {bus.y[IN_W-1], bus.y} + RND;
    r_s    = t_s >>> SHIFT;
    if (r_s > MAX_T) begin
      q_s   = MAX_T[OUT_W-1:0];
      sat_s = 1'b1;
    end else if (r_s < MIN_T) begin
      q_s   = MIN_T[OUT_W-1:0];
      sat_s = 1'b1;
    end else begin
      q_s   = r_s[OUT_W-1:0];
      sat_s = 1'b0;
    end
  end

  // Decimation phase, capture stage and status flags; a new event beats a clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_r       <= '0;
      stage_valid_r <= 1'b0;
      stage_data_r  <= '0;
      sat_sticky    <= 1'b0;
      drop_cnt      <= '0;
    end else begin
      if (bus.in_valid) begin
        phase_r <= (phase_r == PW'(DECIM - 1)) ? '0 : phase_r + PW'(1'b1);
      end
      stage_valid_r <= keep_s;
      if (keep_s) begin
        stage_data_r <= q_s;
      end
      sat_sticky <= (keep_s && sat_s) || (sat_sticky && !clr_flags);
      if (clr_flags) begin
        drop_cnt <= drop_s ? CNT_W'(1'b1) : '0;
      end else if (drop_s && (drop_cnt != '1)) begin
        drop_cnt <= drop_cnt + CNT_W'(1'b1);
      end
    end
  end

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (OUT_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (stage_valid_r),
    .wr_data  (stage_data_r),
    .rd_ready (bus.out_ready),
    .rd_valid (bus.out_valid),
    .rd_data  (bus.out_data),
    .level    (fifo_level),
    .drop     (drop_s)
  );

endmodule
